// File: rtl/servo_pkg.sv
// Shared constants, derivation helpers and FSM state type for the servo slew controller.
package servo_pkg;

    localparam int unsigned CLK_FREQ_DEF     = 32'd25_000_000;
    localparam int unsigned PWM_FREQ_DEF     = 32'd50;
    localparam int unsigned MIN_PULSE_US_DEF = 32'd500;
    localparam int unsigned MAX_PULSE_US_DEF = 32'd2500;
    localparam int unsigned STEP_TICKS_DEF   = 32'd2770;

    function automatic logic [31:0] calc_period(input logic [31:0] clk_freq, input logic [31:0] pwm_freq);
        return clk_freq / pwm_freq;
    endfunction

    function automatic logic [31:0] calc_pulse_ticks(input logic [31:0] clk_freq, input logic [31:0] pulse_us);
        return clk_freq / 32'd1_000_000 * pulse_us;
    endfunction

    function automatic logic [31:0] calc_ticks_per_deg(input logic [31:0] clk_freq, input logic [31:0] min_us,
                                                       input logic [31:0] max_us);
        return (calc_pulse_ticks(clk_freq, max_us) - calc_pulse_ticks(clk_freq, min_us)) / 32'd180;
    endfunction

    localparam logic [31:0] PERIOD_TICKS  = calc_period(CLK_FREQ_DEF, PWM_FREQ_DEF);
    localparam logic [31:0] MIN_TICKS     = calc_pulse_ticks(CLK_FREQ_DEF, MIN_PULSE_US_DEF);
    localparam logic [31:0] TICKS_PER_DEG = calc_ticks_per_deg(CLK_FREQ_DEF, MIN_PULSE_US_DEF, MAX_PULSE_US_DEF);
    localparam logic [31:0] CENTER_TICKS  = MIN_TICKS + 32'd90 * TICKS_PER_DEG;
    localparam logic [7:0]  ANGLE_MAX     = 8'd180;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SLEW = 2'd2
    } state_e;

endpackage

// File: rtl/servo_slew_if.sv
// Command handshake and PWM drive bundle between a command source and the slew controller.
interface servo_slew_if;
    logic        cmd_valid;
    logic [7:0]  cmd_angle;
    logic        cmd_ready;
    logic [31:0] duty_cycle;
    logic [31:0] period;
    logic        frame_tick;
    logic        busy;

    modport master (
        output cmd_valid, cmd_angle,
        input  cmd_ready, duty_cycle, period, frame_tick, busy
    );

    modport slave (
        input  cmd_valid, cmd_angle,
        output cmd_ready, duty_cycle, period, frame_tick, busy
    );
endinterface

// File: rtl/servo_frame_timer.sv
// Free-running PWM frame counter; frame_tick is high for the last cycle of every frame.
module servo_frame_timer #(
    parameter logic [31:0] PERIOD_TICKS = servo_pkg::PERIOD_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    output logic frame_tick
);
    localparam logic [31:0] LAST_CNT = PERIOD_TICKS - 32'd1;
    localparam logic [31:0] PRE_LAST = PERIOD_TICKS - 32'd2;

    logic [31:0] frame_cnt_r;
    logic        frame_tick_r;

    // Counter wraps at LAST_CNT; tick is registered one count early so it coincides with LAST_CNT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r  <= 32'd0;
            frame_tick_r <= 1'b0;
        end else begin
            if (frame_cnt_r == LAST_CNT) begin
                frame_cnt_r <= 32'd0;
            end else begin
                frame_cnt_r <= frame_cnt_r + 32'd1;
            end
            frame_tick_r <= (frame_cnt_r == PRE_LAST);
        end
    end

    assign frame_tick = frame_tick_r;
endmodule

// File: rtl/servo_slew_ctrl.sv
// Angle-command servo controller: converts angles to pulse widths and slews the PWM duty
// toward the target by at most one bounded step per frame.
module servo_slew_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = CLK_FREQ_DEF,
    parameter int unsigned PWM_FREQ     = PWM_FREQ_DEF,
    parameter int unsigned MIN_PULSE_US = MIN_PULSE_US_DEF,
    parameter int unsigned MAX_PULSE_US = MAX_PULSE_US_DEF,
    parameter int unsigned STEP_TICKS   = STEP_TICKS_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    servo_slew_if.slave   bus
);
    localparam logic [31:0] L_PERIOD = calc_period(CLK_FREQ, PWM_FREQ);
    localparam logic [31:0] L_MIN    = calc_pulse_ticks(CLK_FREQ, MIN_PULSE_US);
    localparam logic [31:0] L_TPD    = calc_ticks_per_deg(CLK_FREQ, MIN_PULSE_US, MAX_PULSE_US);
    localparam logic [31:0] L_CENTER = L_MIN + 32'd90 * L_TPD;
    localparam logic [31:0] L_STEP   = STEP_TICKS;

    state_e      state_r, state_s;
    logic [7:0]  angle_r, angle_s;
    logic [31:0] target_r, target_s;
    logic [31:0] duty_r, duty_s;
    logic        ready_r;
    logic        busy_r;
    logic        frame_tick_s;
    logic        transfer_s;
    logic [7:0]  angle_clamped_s;
    logic        up_s;
    logic [31:0] diff_s;

    servo_frame_timer #(.PERIOD_TICKS(L_PERIOD)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick_s)
    );

    assign transfer_s      = bus.cmd_valid && ready_r;
    assign angle_clamped_s = (bus.cmd_angle > ANGLE_MAX) ? ANGLE_MAX : bus.cmd_angle;
    // Subtract in whichever direction keeps the unsigned difference from wrapping.
    assign up_s            = (target_r >= duty_r);
    assign diff_s          = up_s ? (target_r - duty_r) : (duty_r - target_r);

    // Next-state, angle latch, target calculation and per-frame duty step.
    always_comb begin
        state_s  = state_r;
        angle_s  = angle_r;
        target_s = target_r;
        duty_s   = duty_r;
        case (state_r)
            IDLE: begin
                if (transfer_s) begin
                    angle_s = angle_clamped_s;
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                target_s = L_MIN + {24'd0, angle_r} * L_TPD;
                state_s  = SLEW;
            end
            SLEW: begin
                if (frame_tick_s) begin
                    if (diff_s <= L_STEP) begin
                        duty_s  = target_r;
                        state_s = IDLE;
                    end else if (up_s) begin
                        duty_s = duty_r + L_STEP;
                    end else begin
                        duty_s = duty_r - L_STEP;
                    end
                end else begin
                    state_s = SLEW;
                end
                // A new command overrides the IDLE exit but not the step already taken.
                if (transfer_s) begin
                    angle_s = angle_clamped_s;
                    state_s = CALC;
                end else begin
                    angle_s = angle_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; handshake and status flags are registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            angle_r  <= 8'd90;
            target_r <= L_CENTER;
            duty_r   <= L_CENTER;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            angle_r  <= angle_s;
            target_r <= target_s;
            duty_r   <= duty_s;
            ready_r  <= (state_s != CALC);
            busy_r   <= (state_s != IDLE);
        end
    end

    assign bus.cmd_ready  = ready_r;
    assign bus.busy       = busy_r;
    assign bus.duty_cycle = duty_r;
    assign bus.period     = L_PERIOD;
    assign bus.frame_tick = frame_tick_s;
endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Directed bench for servo_slew_ctrl with a queue of expected per-frame duty values.
module tb_servo_slew_ctrl;
    localparam int unsigned CLK_F  = 25_000_000;
    localparam int unsigned PWM_F  = 125_000;
    localparam int unsigned PER    = CLK_F / PWM_F;
    localparam logic [31:0] MIN_T  = 32'd12_500;
    localparam logic [31:0] TPD    = 32'd277;
    localparam logic [31:0] STEP   = 32'd2770;
    localparam logic [31:0] CENTER = 32'd37_430;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    servo_slew_if bus();

    servo_slew_ctrl #(.CLK_FREQ(CLK_F), .PWM_FREQ(PWM_F)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_duty;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_angle = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_duty = CENTER;
    endtask

    task automatic wait_tick(output bit got);
        got = 1'b0;
        for (int i = 0; i < 2 * PER + 4; i++) begin
            @(negedge clk);
            if (bus.frame_tick === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("tick_timeout", {31'd0, got}, 32'd1);
    endtask

    // Independent model: list every duty value the servo should pass through toward the new target.
    task automatic plan(input logic [7:0] angle);
        logic [31:0] t, d;
        t = MIN_T + ((angle > 8'd180) ? 32'd180 : {24'd0, angle}) * TPD;
        d = m_duty;
        exp_q.delete();
        if (d == t) exp_q.push_back(d);
        while (d != t) begin
            if (t > d) d = (t - d <= STEP) ? t : d + STEP;
            else       d = (d - t <= STEP) ? t : d - STEP;
            exp_q.push_back(d);
        end
    endtask

    task automatic send(input logic [7:0] angle, input string tag);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_angle = angle;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check({tag, "_ready_low"}, {31'd0, bus.cmd_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        plan(angle);
        @(posedge clk);
        #1;
        check({tag, "_ready_back"}, {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    task automatic run_frames(input int n, input string tag);
        bit got;
        logic [31:0] e;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) break;
            e = exp_q.pop_front();
            wait_tick(got);
            check({tag, "_hold"}, bus.duty_cycle, m_duty);
            @(posedge clk);
            #1;
            check({tag, "_duty"}, bus.duty_cycle, e);
            m_duty = e;
            check({tag, "_busy"}, {31'd0, bus.busy}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        bit got;
        int cnt;
        logic [31:0] e;

        // Reset values
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_angle = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_duty", bus.duty_cycle, CENTER);
        check("rst_period", bus.period, PER);
        check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_tick", {31'd0, bus.frame_tick}, 32'd0);
        do_reset();

        // Frame tick spacing
        wait_tick(got);
        cnt = 0;
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk);
            cnt++;
            if (bus.frame_tick === 1'b1) break;
        end
        check("tick_spacing", cnt, PER);

        // Full slew center -> 180
        send(8'd180, "c180");
        check("c180_nsteps", exp_q.size(), 32'd9);
        run_frames(exp_q.size(), "c180");
        check("c180_final", bus.duty_cycle, 32'd62_360);

        // Small move within one step
        do_reset();
        send(8'd95, "c95");
        run_frames(exp_q.size(), "c95");
        check("c95_final", bus.duty_cycle, 32'd38_815);

        // Out-of-range angle is clamped, then a full sweep to 0
        send(8'd200, "c200");
        run_frames(exp_q.size(), "c200");
        check("c200_final", bus.duty_cycle, 32'd62_360);
        send(8'd0, "c0");
        check("c0_nsteps", exp_q.size(), 32'd18);
        run_frames(exp_q.size(), "c0");
        check("c0_final", bus.duty_cycle, MIN_T);

        // Redirect mid-slew
        do_reset();
        send(8'd180, "mid");
        run_frames(3, "mid");
        check("mid_after3", bus.duty_cycle, 32'd45_740);
        send(8'd0, "redir");
        run_frames(exp_q.size(), "redir");
        check("redir_final", bus.duty_cycle, MIN_T);

        // Command coinciding with frame_tick in SLEW, then reset mid-slew
        do_reset();
        send(8'd180, "sim");
        run_frames(1, "sim");
        wait_tick(got);
        bus.cmd_valid = 1'b1;
        bus.cmd_angle = 8'd0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        e = exp_q.pop_front();
        check("sim_step", bus.duty_cycle, e);
        check("sim_calc_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("sim_busy", {31'd0, bus.busy}, 32'd1);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_duty", bus.duty_cycle, CENTER);
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        m_duty = CENTER;
        wait_tick(got);
        @(posedge clk);
        #1;
        check("post_rst_duty", bus.duty_cycle, CENTER);
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
